writeback_unit: RTL and testbench

Write-side front end of the 32x32 register file. Accepts ALU results and memory-load results, buffers loads in a small FIFO, and arbitrates between the two so the register file receives at most one registered write per cycle on `we`/`rd`/`wdata`. It also exports a pending-load scoreboard, which the issue logic uses to avoid RAW and WAW hazards on registers still waiting for a load.

---
 rtl/writeback_unit_if.sv | 40 ++++
 rtl/writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_writeback_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Bundle of the writeback unit's handshake and register-file bus signals.
// DEPTH must match the DEPTH of the writeback_unit it is bound to, because
// fifo_count is sized from it.
//
// Handshake rule, for both producer channels: a transfer happens in a cycle
// exactly when valid && ready are both high at the rising edge. A producer
// keeps valid and its payload stable until that transfer. Ready may depend
// only on the unit's own state and never on valid.
interface writeback_unit_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [31:0]   alu_data;
  logic          ld_valid;
  logic          ld_ready;
  logic [4:0]    ld_rd;
  logic [31:0]   ld_data;
  logic          we;
  logic [4:0]    rd;
  logic [31:0]   wdata;
  logic [31:0]   busy_mask;
  logic [CW-1:0] fifo_count;

  // Producer/observer side: drives the ALU and load channels and watches the
  // register-file write port and the scoreboard.
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, we, rd, wdata, busy_mask, fifo_count
  );

  // Writeback unit side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, we, rd, wdata, busy_mask, fifo_count
  );
endinterface

// File: rtl/writeback_unit.sv
// Write-side front end of the 32x32 register file. ALU results and queued
// load results compete for a single registered write port. Loads wait in a
// circular FIFO. A starvation counter forces a one-cycle DRAIN state so that
// a steady ALU stream cannot block loads forever. busy_mask reports which
// registers still have a queued load.
// Optional feature macro: WB_LOAD_BYPASS_EN. When it is defined, a load that
// arrives while the FIFO is empty and the ALU is not accepted goes straight
// to the write port.
module writeback_unit #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  writeback_unit_if.slave bus,
  output logic            dbg_drain_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {NORMAL = 1'b0, DRAIN = 1'b1} state_e;

  state_e        state_q;
  logic [3:0]    starve_q;
  logic [CW-1:0] count_q;
  logic [PW-1:0] rptr_q, wptr_q;
  logic [DEPTH-1:0] vld_q;
  logic [4:0]    rd_mem_q   [DEPTH];
  logic [31:0]   data_mem_q [DEPTH];
  logic          we_q;
  logic [4:0]    rd_q;
  logic [31:0]   wdata_q;

  logic          empty, full, alu_fire, pop, push, bypass;
  logic          slot_fire;
  logic [4:0]    slot_rd;
  logic [31:0]   slot_data;
  logic [31:0]   busy_d;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign alu_fire = bus.alu_valid && (state_q == NORMAL);
  // The head is serviced whenever the ALU leaves the slot free, and always in DRAIN.
  assign pop      = !empty && ((state_q == DRAIN) || !bus.alu_valid);
`ifdef WB_LOAD_BYPASS_EN
  // An empty FIFO implies NORMAL, so only the ALU can contend for the slot here.
  assign bypass   = bus.ld_valid && empty && !alu_fire;
`else
  assign bypass   = 1'b0;
`endif
  assign push     = bus.ld_valid && !full && !bypass;

  // Select the winner of this cycle's single write slot.
  always_comb begin
    slot_fire = 1'b0;
    slot_rd   = '0;
    slot_data = '0;
    if (alu_fire) begin
      slot_fire = 1'b1;
      slot_rd   = bus.alu_rd;
      slot_data = bus.alu_data;
    end else if (pop) begin
      slot_fire = 1'b1;
      slot_rd   = rd_mem_q[rptr_q];
      slot_data = data_mem_q[rptr_q];
    end else if (bypass) begin
      slot_fire = 1'b1;
      slot_rd   = bus.ld_rd;
      slot_data = bus.ld_data;
    end
  end

  // Arbiter FSM and starvation counter; the counter clears on entry to DRAIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= NORMAL;
      starve_q <= '0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (empty || pop) begin
            starve_q <= '0;
          end else if (starve_q == 4'(STARVE_LIMIT - 1)) begin
            state_q  <= DRAIN;
            starve_q <= '0;
          end else begin
            starve_q <= starve_q + 4'd1;
          end
        end
        default: begin
          state_q  <= NORMAL;
          starve_q <= '0;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and per-entry valid bits for the scoreboard.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      if (pop) begin
        rptr_q        <= rptr_q + PW'(1);
        vld_q[rptr_q] <= 1'b0;
      end
      if (push) begin
        wptr_q        <= wptr_q + PW'(1);
        vld_q[wptr_q] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // FIFO payload storage; contents are meaningful only where vld_q is set.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem_q[wptr_q]   <= bus.ld_rd;
      data_mem_q[wptr_q] <= bus.ld_data;
    end
  end

  // Registered write port. A write to x0 is consumed but never asserts we.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      rd_q    <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= slot_fire && (slot_rd != 5'd0);
      if (slot_fire && (slot_rd != 5'd0)) begin
        rd_q    <= slot_rd;
        wdata_q <= slot_data;
      end
    end
  end

  // Scoreboard: one-hot of every queued destination. x0 is never marked busy.
  always_comb begin
    busy_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) busy_d = busy_d | (32'd1 << rd_mem_q[i]);
    end
    busy_d[0] = 1'b0;
  end

  assign bus.alu_ready  = (state_q == NORMAL);
  assign bus.ld_ready   = !full;
  assign bus.we         = we_q;
  assign bus.rd         = rd_q;
  assign bus.wdata      = wdata_q;
  assign bus.busy_mask  = busy_d;
  assign bus.fifo_count = count_q;
  assign dbg_drain_o    = (state_q == DRAIN);
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit (DEPTH=2, STARVE_LIMIT=4).
// Inputs are applied 1 time unit after a rising edge. Outputs are sampled at
// the same point, so registered outputs show the result of that edge.
module tb_writeback_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_drain;
  int   checks = 0;
  int   fails  = 0;

  writeback_unit_if #(.DEPTH(2)) bus ();

  writeback_unit #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_drain_o (dbg_drain)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid  = 1'b0; bus.ld_rd  = '0; bus.ld_data  = '0;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0;
    #12;
    checks++; if (bus.we !== 1'b0) begin fails++; $display("FAIL reset_we got %b want 0", bus.we); end
    checks++; if (bus.rd !== 5'd0) begin fails++; $display("FAIL reset_rd got %0d want 0", bus.rd); end
    checks++; if (bus.wdata !== 32'd0) begin fails++; $display("FAIL reset_wdata got %h want 0", bus.wdata); end
    checks++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL reset_alu_ready got %b want 1", bus.alu_ready); end
    checks++; if (bus.ld_ready !== 1'b1) begin fails++; $display("FAIL reset_ld_ready got %b want 1", bus.ld_ready); end
    checks++; if (bus.busy_mask !== 32'd0) begin fails++; $display("FAIL reset_busy got %h want 0", bus.busy_mask); end
    checks++; if (bus.fifo_count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.fifo_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu_path();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    idle();
    checks++; if (bus.we !== 1'b1) begin fails++; $display("FAIL alu_we got %b want 1", bus.we); end
    checks++; if (bus.rd !== 5'd5) begin fails++; $display("FAIL alu_rd got %0d want 5", bus.rd); end
    checks++; if (bus.wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL alu_wdata got %h want deadbeef", bus.wdata); end
    tick();
    checks++; if (bus.we !== 1'b0) begin fails++; $display("FAIL alu_we_drop got %b want 0", bus.we); end
    checks++; if (bus.rd !== 5'd5 || bus.wdata !== 32'hDEADBEEF) begin fails++; $display("FAIL alu_hold got rd=%0d wdata=%h want rd=5 wdata=deadbeef", bus.rd, bus.wdata); end
  endtask

  // The ALU is kept busy so the FIFO is not drained while it fills.
  task automatic test_load_fill();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'hA1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd7; bus.ld_data = 32'h11;
    tick();
    bus.alu_data = 32'hA2;
    bus.ld_rd = 5'd9; bus.ld_data = 32'h22;
    checks++; if (bus.fifo_count !== 2'd1) begin fails++; $display("FAIL fill_count1 got %0d want 1", bus.fifo_count); end
    checks++; if (bus.busy_mask !== 32'h80) begin fails++; $display("FAIL fill_busy1 got %h want 80", bus.busy_mask); end
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd1 || bus.wdata !== 32'hA1) begin fails++; $display("FAIL fill_alu1 got we=%b rd=%0d wdata=%h want 1/1/a1", bus.we, bus.rd, bus.wdata); end
    tick();
    bus.ld_valid = 1'b0;
    bus.alu_rd = 5'd2; bus.alu_data = 32'hA3;
    checks++; if (bus.fifo_count !== 2'd2) begin fails++; $display("FAIL fill_count2 got %0d want 2", bus.fifo_count); end
    checks++; if (bus.busy_mask !== 32'h280) begin fails++; $display("FAIL fill_busy2 got %h want 280", bus.busy_mask); end
    checks++; if (bus.ld_ready !== 1'b0) begin fails++; $display("FAIL fill_ld_ready got %b want 0", bus.ld_ready); end
    tick();
    bus.alu_valid = 1'b0;
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd2 || bus.wdata !== 32'hA3) begin fails++; $display("FAIL fill_alu3 got we=%b rd=%0d wdata=%h want 1/2/a3", bus.we, bus.rd, bus.wdata); end
    checks++; if (bus.fifo_count !== 2'd2) begin fails++; $display("FAIL fill_count_hold got %0d want 2", bus.fifo_count); end
    tick();
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd7 || bus.wdata !== 32'h11) begin fails++; $display("FAIL fill_ld7 got we=%b rd=%0d wdata=%h want 1/7/11", bus.we, bus.rd, bus.wdata); end
    checks++; if (bus.busy_mask !== 32'h200 || bus.fifo_count !== 2'd1) begin fails++; $display("FAIL fill_after7 got busy=%h count=%0d want 200/1", bus.busy_mask, bus.fifo_count); end
    tick();
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd9 || bus.wdata !== 32'h22) begin fails++; $display("FAIL fill_ld9 got we=%b rd=%0d wdata=%h want 1/9/22", bus.we, bus.rd, bus.wdata); end
    checks++; if (bus.busy_mask !== 32'h0 || bus.fifo_count !== 2'd0) begin fails++; $display("FAIL fill_empty got busy=%h count=%0d want 0/0", bus.busy_mask, bus.fifo_count); end
    tick();
  endtask

  task automatic test_starvation();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'h55;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd3; bus.ld_data = 32'h33;
    tick();
    bus.ld_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL starve_ready_c%0d got %b want 1", k, bus.alu_ready); end
      tick();
    end
    checks++; if (bus.alu_ready !== 1'b0 || dbg_drain !== 1'b1) begin fails++; $display("FAIL starve_drain got ready=%b drain=%b want 0/1", bus.alu_ready, dbg_drain); end
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd10) begin fails++; $display("FAIL starve_alu_pre got we=%b rd=%0d want 1/10", bus.we, bus.rd); end
    tick();
    checks++; if (bus.alu_ready !== 1'b1) begin fails++; $display("FAIL starve_ready_back got %b want 1", bus.alu_ready); end
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd3 || bus.wdata !== 32'h33) begin fails++; $display("FAIL starve_ld3 got we=%b rd=%0d wdata=%h want 1/3/33", bus.we, bus.rd, bus.wdata); end
    checks++; if (bus.fifo_count !== 2'd0) begin fails++; $display("FAIL starve_count got %0d want 0", bus.fifo_count); end
    tick();
    idle();
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd10 || bus.wdata !== 32'h55) begin fails++; $display("FAIL starve_held_alu got we=%b rd=%0d wdata=%h want 1/10/55", bus.we, bus.rd, bus.wdata); end
    tick();
    checks++; if (bus.we !== 1'b0) begin fails++; $display("FAIL starve_quiet got %b want 0", bus.we); end
  endtask

  task automatic test_x0_discard();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h77;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd0; bus.ld_data = 32'h88;
    tick();
    idle();
    checks++; if (bus.we !== 1'b0) begin fails++; $display("FAIL x0_we_alu got %b want 0", bus.we); end
    checks++; if (bus.fifo_count !== 2'd1 || bus.busy_mask !== 32'd0) begin fails++; $display("FAIL x0_queued got count=%0d busy=%h want 1/0", bus.fifo_count, bus.busy_mask); end
    tick();
    checks++; if (bus.we !== 1'b0) begin fails++; $display("FAIL x0_we_ld got %b want 0", bus.we); end
    checks++; if (bus.fifo_count !== 2'd0) begin fails++; $display("FAIL x0_count got %0d want 0", bus.fifo_count); end
    checks++; if (bus.rd !== 5'd10 || bus.wdata !== 32'h55) begin fails++; $display("FAIL x0_hold got rd=%0d wdata=%h want 10/55", bus.rd, bus.wdata); end
    tick();
  endtask

  task automatic test_idle_load();
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd4; bus.ld_data = 32'h44;
    tick();
    idle();
`ifdef WB_LOAD_BYPASS_EN
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd4 || bus.wdata !== 32'h44) begin fails++; $display("FAIL byp_write got we=%b rd=%0d wdata=%h want 1/4/44", bus.we, bus.rd, bus.wdata); end
    checks++; if (bus.fifo_count !== 2'd0 || bus.busy_mask !== 32'd0) begin fails++; $display("FAIL byp_fifo got count=%0d busy=%h want 0/0", bus.fifo_count, bus.busy_mask); end
    tick();
    checks++; if (bus.we !== 1'b0) begin fails++; $display("FAIL byp_once got %b want 0", bus.we); end
`else
    checks++; if (bus.we !== 1'b0) begin fails++; $display("FAIL ld_n1_we got %b want 0", bus.we); end
    checks++; if (bus.fifo_count !== 2'd1 || bus.busy_mask !== 32'h10) begin fails++; $display("FAIL ld_n1_fifo got count=%0d busy=%h want 1/10", bus.fifo_count, bus.busy_mask); end
    tick();
    checks++; if (bus.we !== 1'b1 || bus.rd !== 5'd4 || bus.wdata !== 32'h44) begin fails++; $display("FAIL ld_n2_write got we=%b rd=%0d wdata=%h want 1/4/44", bus.we, bus.rd, bus.wdata); end
    checks++; if (bus.fifo_count !== 2'd0 || bus.busy_mask !== 32'd0) begin fails++; $display("FAIL ld_n2_fifo got count=%0d busy=%h want 0/0", bus.fifo_count, bus.busy_mask); end
`endif
    tick();
  endtask

  task automatic test_reset_mid();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'hB1;
    bus.ld_valid = 1'b1; bus.ld_rd = 5'd12; bus.ld_data = 32'hC1;
    tick();
    bus.ld_rd = 5'd13; bus.ld_data = 32'hC2;
    tick();
    idle();
    checks++; if (bus.fifo_count !== 2'd2) begin fails++; $display("FAIL rmid_pre_count got %0d want 2", bus.fifo_count); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.fifo_count !== 2'd0 || bus.busy_mask !== 32'd0) begin fails++; $display("FAIL rmid_fifo got count=%0d busy=%h want 0/0", bus.fifo_count, bus.busy_mask); end
    checks++; if (bus.we !== 1'b0 || bus.ld_ready !== 1'b1 || bus.alu_ready !== 1'b1) begin fails++; $display("FAIL rmid_ctrl got we=%b ld_ready=%b alu_ready=%b want 0/1/1", bus.we, bus.ld_ready, bus.alu_ready); end
    #1 rst_n = 1'b1;
    tick();
    checks++; if (bus.we !== 1'b0 || bus.fifo_count !== 2'd0) begin fails++; $display("FAIL rmid_lost got we=%b count=%0d want 0/0", bus.we, bus.fifo_count); end
  endtask

  initial begin
    test_reset();
    test_alu_path();
    test_load_fill();
    test_starvation();
    test_x0_discard();
    test_idle_load();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end
endmodule
